// File: rtl/ecc_scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for projective scalar multiplication R = k*P.
// Define ECC_CTRL_CONST_TIME_EN to follow every post-leading-one doubling with an add (dummy for zero bits).
module ecc_scalar_mult_ctrl #(
   parameter int W      = 4,
   parameter int K      = 4,
   parameter int OP_LAT = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [K-1:0] k,
   input  logic [W-1:0] px,
   input  logic [W-1:0] py,
   input  logic [W-1:0] pz,
   output logic         busy,
   output logic         done,
   output logic         inf,
   output logic [W-1:0] rx,
   output logic [W-1:0] ry,
   output logic [W-1:0] rz,
   output logic         op_valid,
   output logic         op_dbl,
   output logic [W-1:0] op_x0,
   output logic [W-1:0] op_y0,
   output logic [W-1:0] op_z0,
   output logic [W-1:0] op_x1,
   output logic [W-1:0] op_y1,
   output logic [W-1:0] op_z1,
   input  logic [W-1:0] op_x2,
   input  logic [W-1:0] op_y2,
   input  logic [W-1:0] op_z2
);

   localparam int CW = $clog2(OP_LAT) + 1;
   localparam int IW = (K > 1) ? $clog2(K) : 1;

   typedef enum logic [2:0] {IDLE, SCAN, DBL, ADD, DONE} state_t;

   state_t         state, state_nxt;
   logic [IW-1:0]  idx, idx_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic [K-1:0]   k_q;
   logic [W-1:0]   p_x, p_y, p_z;
   logic [W-1:0]   r_x, r_y, r_z;
   logic [W-1:0]   r_x_nxt, r_y_nxt, r_z_nxt;
   logic [W-1:0]   h_x0, h_y0, h_z0, h_x1, h_y1, h_z1;
   logic [W-1:0]   o_x1, o_y1, o_z1;
   logic [W-1:0]   res_x, res_y, res_z;
   logic           inf_q, inf_nxt;
   logic           op_last, bit_cur, idx_zero;

   assign op_last  = (cnt == CW'(OP_LAT - 1));
   assign bit_cur  = k_q[idx];
   assign idx_zero = (idx == '0);

   // NOTE: every signal driven here gets a default first so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      r_x_nxt   = r_x;
      r_y_nxt   = r_y;
      r_z_nxt   = r_z;
      inf_nxt   = inf_q;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SCAN;
               idx_nxt   = IW'(K - 1);
               inf_nxt   = 1'b0;
            end
         end
         SCAN: begin
            cnt_nxt = '0;
            if (bit_cur) begin
               r_x_nxt = p_x;
               r_y_nxt = p_y;
               r_z_nxt = p_z;
               if (idx_zero) state_nxt = DONE;
               else begin
                  idx_nxt   = idx - 1'b1;
                  state_nxt = DBL;
               end
            end else if (idx_zero) begin
               r_x_nxt   = '0;
               r_y_nxt   = W'(1);
               r_z_nxt   = '0;
               inf_nxt   = 1'b1;
               state_nxt = DONE;
            end else begin
               idx_nxt = idx - 1'b1;
            end
         end
         DBL: begin
            if (op_last) begin
               cnt_nxt = '0;
               r_x_nxt = op_x2;
               r_y_nxt = op_y2;
               r_z_nxt = op_z2;
`ifdef ECC_CTRL_CONST_TIME_EN
               state_nxt = ADD;
`else
               if (bit_cur) state_nxt = ADD;
               else if (idx_zero) state_nxt = DONE;
               else idx_nxt = idx - 1'b1;
`endif
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ADD: begin
            if (op_last) begin
               cnt_nxt = '0;
`ifdef ECC_CTRL_CONST_TIME_EN
               // A zero bit makes this a dummy add: the sum is presented but dropped.
               if (bit_cur) begin
`else
               begin
`endif
                  r_x_nxt = op_x2;
                  r_y_nxt = op_y2;
                  r_z_nxt = op_z2;
               end
               if (idx_zero) state_nxt = DONE;
               else begin
                  idx_nxt   = idx - 1'b1;
                  state_nxt = DBL;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy     = (state != IDLE);
   assign done     = (state == DONE);
   assign op_valid = (state == DBL) || (state == ADD);
   assign op_dbl   = (state == DBL);
   assign o_x1     = op_dbl ? r_x : p_x;
   assign o_y1     = op_dbl ? r_y : p_y;
   assign o_z1     = op_dbl ? r_z : p_z;
   // Operands follow R live during an op and fall back to the last presented values otherwise.
   assign op_x0    = op_valid ? r_x  : h_x0;
   assign op_y0    = op_valid ? r_y  : h_y0;
   assign op_z0    = op_valid ? r_z  : h_z0;
   assign op_x1    = op_valid ? o_x1 : h_x1;
   assign op_y1    = op_valid ? o_y1 : h_y1;
   assign op_z1    = op_valid ? o_z1 : h_z1;
   assign rx       = res_x;
   assign ry       = res_y;
   assign rz       = res_z;
   assign inf      = inf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
         k_q   <= '0;
         {p_x, p_y, p_z}    <= '0;
         {r_x, r_y, r_z}    <= '0;
         {h_x0, h_y0, h_z0} <= '0;
         {h_x1, h_y1, h_z1} <= '0;
         {res_x, res_y, res_z} <= '0;
         inf_q <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
         r_x   <= r_x_nxt;
         r_y   <= r_y_nxt;
         r_z   <= r_z_nxt;
         inf_q <= inf_nxt;
         if (state == IDLE && start) begin
            k_q <= k;
            p_x <= px;
            p_y <= py;
            p_z <= pz;
         end
         if (op_valid) begin
            {h_x0, h_y0, h_z0} <= {r_x, r_y, r_z};
            {h_x1, h_y1, h_z1} <= {o_x1, o_y1, o_z1};
         end
         if (state_nxt == DONE && state != DONE) begin
            res_x <= r_x_nxt;
            res_y <= r_y_nxt;
            res_z <= r_z_nxt;
         end
      end
   end

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// Bench for ecc_scalar_mult_ctrl: two instances (OP_LAT 1 and 3) on a sum-mod-16 add stub,
// checked against an arithmetic model of k*P, op order, operand values and latency.
module tb_ecc_scalar_mult_ctrl;

   localparam int W = 4;
   localparam int K = 4;
`ifdef ECC_CTRL_CONST_TIME_EN
   localparam bit CT = 1'b1;
`else
   localparam bit CT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   start = '0;
   logic [K-1:0] k_in = '0;
   logic [W-1:0] px_in = '0, py_in = '0, pz_in = '0;

   logic [1:0]   busy, done, inf, op_valid, op_dbl;
   logic [W-1:0] rx [2], ry [2], rz [2];
   logic [W-1:0] ox0 [2], oy0 [2], oz0 [2], ox1 [2], oy1 [2], oz1 [2];
   logic [W-1:0] ox2 [2], oy2 [2], oz2 [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ecc_scalar_mult_ctrl #(.W(W), .K(K), .OP_LAT(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .k(k_in),
      .px(px_in), .py(py_in), .pz(pz_in),
      .busy(busy[0]), .done(done[0]), .inf(inf[0]),
      .rx(rx[0]), .ry(ry[0]), .rz(rz[0]),
      .op_valid(op_valid[0]), .op_dbl(op_dbl[0]),
      .op_x0(ox0[0]), .op_y0(oy0[0]), .op_z0(oz0[0]),
      .op_x1(ox1[0]), .op_y1(oy1[0]), .op_z1(oz1[0]),
      .op_x2(ox2[0]), .op_y2(oy2[0]), .op_z2(oz2[0]));

   ecc_scalar_mult_ctrl #(.W(W), .K(K), .OP_LAT(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .k(k_in),
      .px(px_in), .py(py_in), .pz(pz_in),
      .busy(busy[1]), .done(done[1]), .inf(inf[1]),
      .rx(rx[1]), .ry(ry[1]), .rz(rz[1]),
      .op_valid(op_valid[1]), .op_dbl(op_dbl[1]),
      .op_x0(ox0[1]), .op_y0(oy0[1]), .op_z0(oz0[1]),
      .op_x1(ox1[1]), .op_y1(oy1[1]), .op_z1(oz1[1]),
      .op_x2(ox2[1]), .op_y2(oy2[1]), .op_z2(oz2[1]));

   // Add-unit stub: component-wise sum mod 16.
   for (genvar g = 0; g < 2; g++) begin : g_stub
      assign ox2[g] = ox0[g] + ox1[g];
      assign oy2[g] = oy0[g] + oy1[g];
      assign oz2[g] = oz0[g] + oz1[g];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Model: op list from the scalar bits (0=double, 1=real add, 2=dummy add), and the latency.
   function automatic int model_ops(input logic [K-1:0] kv, output int ops [$]);
      int p;
      ops = {};
      if (kv == 0) return K;
      p = 0;
      for (int i = 0; i < K; i++) if (kv[i]) p = i;
      for (int i = p - 1; i >= 0; i--) begin
         ops.push_back(0);
         if (kv[i]) ops.push_back(1);
         else if (CT) ops.push_back(2);
      end
      return K - p;
   endfunction

   function automatic int model_lat(input logic [K-1:0] kv, input int lat);
      int ops [$];
      int scan;
      scan = model_ops(kv, ops);
      return scan + lat * ops.size();
   endfunction

   task automatic run_cmd(input int d, input logic [K-1:0] kv,
                          input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] z,
                          input bit inj_busy, input bit inj_done, output int seen_lat);
      int lat, cyc, opc, code, ax, ay, az;
      int ops [$];
      logic [3*W-1:0] first0, first1, exp1;
      logic [3*W-1:0] exp_r;
      lat = (d == 0) ? 1 : 3;
      void'(model_ops(kv, ops));
      ax = x; ay = y; az = z;
      first0 = '0; first1 = '0;
      if (kv == 0) exp_r = {W'(0), W'(1), W'(0)};
      else exp_r = {W'(x * kv), W'(y * kv), W'(z * kv)};

      @(negedge clk);
      k_in = kv; px_in = x; py_in = y; pz_in = z;
      start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      check("busy_after_start", busy[d], 1'b1);
      cyc = 0;
      opc = 0;
      while (!done[d] && cyc < 500) begin
         if (op_valid[d]) begin
            if (opc % lat == 0) begin
               if (ops.size() == 0) begin
                  check("op_unexpected", 1, 0);
                  code = 0;
               end else code = ops.pop_front();
               check("op_is_dbl", op_dbl[d], code == 0);
               first0 = {ox0[d], oy0[d], oz0[d]};
               first1 = {ox1[d], oy1[d], oz1[d]};
               exp1 = (code == 0) ? {W'(ax), W'(ay), W'(az)} : {x, y, z};
               check("op0_is_R", first0, {W'(ax), W'(ay), W'(az)});
               check("op1_value", first1, exp1);
               if (code == 0) begin
                  ax = 2 * ax; ay = 2 * ay; az = 2 * az;
               end else if (code == 1) begin
                  ax = ax + x; ay = ay + y; az = az + z;
               end
            end else begin
               check("op0_held", {ox0[d], oy0[d], oz0[d]}, first0);
               check("op1_held", {ox1[d], oy1[d], oz1[d]}, first1);
            end
            opc++;
         end
         @(negedge clk);
         cyc++;
         if (inj_busy && cyc == 1) begin
            k_in = ~kv; px_in = x + 4'd3; py_in = y + 4'd7; pz_in = z + 4'd1;
            start[d] = 1'b1;
         end else start[d] = 1'b0;
      end
      start[d] = 1'b0;
      seen_lat = cyc;
      check("latency", cyc, model_lat(kv, lat));
      check("ops_left", ops.size(), 0);
      check("done", done[d], 1'b1);
      check("inf", inf[d], kv == 0);
      check("result", {rx[d], ry[d], rz[d]}, exp_r);
      if (inj_done) start[d] = 1'b1;
      @(negedge clk);
      start[d] = 1'b0;
      check("idle_after_done", busy[d], 1'b0);
      check("done_pulse_1cyc", done[d], 1'b0);
      check("result_held", {rx[d], ry[d], rz[d]}, exp_r);
   endtask

   initial begin
      int l0, l1;
      bit saw_done;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_busy", busy[d], 1'b0);
         check("rst_done", done[d], 1'b0);
         check("rst_inf", inf[d], 1'b0);
         check("rst_r", {rx[d], ry[d], rz[d]}, 12'h0);
         check("rst_opv", {op_valid[d], op_dbl[d]}, 2'b00);
         check("rst_ops", {ox0[d], oy0[d], oz0[d], ox1[d], oy1[d], oz1[d]}, 24'h0);
      end
      rst_n = 1'b1;

      run_cmd(0, 4'b0101, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0, l0);
      check("lat_0101", l0, 5);
      run_cmd(0, 4'b1111, 4'd2, 4'd1, 4'd1, 1'b0, 1'b1, l0);
      run_cmd(0, 4'b0000, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0, l0);
      check("lat_0000", l0, 4);
      run_cmd(1, 4'b0001, 4'd5, 4'd3, 4'd1, 1'b0, 1'b0, l0);
      check("lat_0001", l0, 4);
      run_cmd(1, 4'b0011, 4'd5, 4'd3, 4'd1, 1'b0, 1'b0, l0);

      // Reset during the second doubling of k=0101.
      @(negedge clk);
      k_in = 4'b0101; px_in = 4'd2; py_in = 4'd1; pz_in = 4'd1;
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_dbl", {op_valid[0], op_dbl[0]}, 2'b11);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", busy[0], 1'b0);
      check("arst_opv", {op_valid[0], op_dbl[0], done[0], inf[0]}, 4'b0000);
      check("arst_r", {rx[0], ry[0], rz[0]}, 12'h0);
      check("arst_ops", {ox0[0], oy0[0], oz0[0], ox1[0], oy1[0], oz1[0]}, 24'h0);
      saw_done = 1'b0;
      repeat (2) begin
         @(negedge clk);
         saw_done |= done[0];
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         saw_done |= done[0];
      end
      check("no_done_after_rst", saw_done, 1'b0);
      check("idle_after_rst", busy[0], 1'b0);

      run_cmd(0, 4'b0101, 4'd2, 4'd1, 4'd1, 1'b1, 1'b1, l0);

      // Hamming-weight dependence of the latency.
      run_cmd(0, 4'b0101, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0, l0);
      run_cmd(0, 4'b0111, 4'd2, 4'd1, 4'd1, 1'b0, 1'b0, l1);
      check("lat_0101_vs_0111", l1 - l0, CT ? 0 : 1);

      for (int i = 0; i < 24; i++) begin
         run_cmd(int'($urandom_range(0, 1)), K'($urandom), W'($urandom), W'($urandom),
                 W'($urandom), 1'($urandom), 1'($urandom), l0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
